// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - state_e   : loader FSM state encoding
//   - LEN_BYTES : number of stream bytes that form the load length
//   - LEN_W     : width of the assembled length word
//   - CSUM_W    : width of the running payload checksum
//   - len_ok()  : length acceptance rule (non-zero, fits IMEM, word multiple)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   localparam int unsigned LEN_BYTES = 4;
   localparam int unsigned LEN_W     = 8 * LEN_BYTES;
   localparam int unsigned CSUM_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   // A load is only accepted if it is non-empty, fits in IMEM and covers
   // whole 32-bit instruction words.
   function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                   input logic [LEN_W-1:0] max_len);
      return (len != '0) && (len <= max_len) && (len[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/le_word_assembler.sv
// -----------------------------------------------------------------------------
// le_word_assembler
// Builds a little-endian word from a byte stream: each shift places the new
// byte at the top and moves older bytes down, so after LEN_BYTES shifts the
// first byte sits in bits [7:0].
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : clear the word to zero (has priority over shift_i)
//   shift_i     : shift byte_i into the word
//   byte_i      : incoming byte
//   word_o      : registered word
//   word_nxt_o  : value the word takes at the next edge (lets the caller
//                 judge the completed word in the same cycle as the last byte)
// -----------------------------------------------------------------------------
module le_word_assembler
   import imem_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             shift_i,
   input  logic [7:0]       byte_i,
   output logic [LEN_W-1:0] word_o,
   output logic [LEN_W-1:0] word_nxt_o
);

   logic [LEN_W-1:0] word_q, word_d;

   always_comb begin
      word_d = word_q;
      if (clr_i) begin
         word_d = '0;
      end else if (shift_i) begin
         word_d = {byte_i, word_q[LEN_W-1:8]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word_o     = word_q;
   assign word_nxt_o = word_d;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program image from a byte stream into instruction memory.
// Stream format after a start request:
//   4 length bytes (LSB first), L payload bytes, 1 checksum byte
//   (checksum = sum of payload bytes modulo 256).
// Payload byte k is written to IMEM byte address k one cycle after it is
// accepted. The core is held until a load finishes with a good checksum.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle load request (honoured in IDLE, DONE, ERR)
//   rx_valid   : source byte available on rx_data
//   rx_data    : stream byte
//   rx_ready   : loader accepts a byte this cycle
//   wr_en      : IMEM byte write strobe
//   wr_addr    : IMEM byte address
//   wr_data    : IMEM write byte
//   busy       : load in progress
//   done       : last load completed with a good checksum
//   err        : last load rejected (bad length or checksum)
//   cpu_hold   : stall the core while IMEM content is not known-good
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned IMEM_SIZE = 1024
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cpu_hold
);

   localparam logic [LEN_W-1:0] MAX_LEN       = LEN_W'(IMEM_SIZE);
   localparam logic [LEN_W-1:0] LAST_LEN_BYTE = LEN_W'(LEN_BYTES - 1);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [CSUM_W-1:0] acc_q, acc_d;
   logic              wr_en_q, wr_en_d;
   logic [31:0]       wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;

   logic              accept;
   logic              len_clr;
   logic              len_shift;
   logic [LEN_W-1:0]  len_word;
   logic [LEN_W-1:0]  len_nxt;

   le_word_assembler u_len (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (len_clr),
      .shift_i    (len_shift),
      .byte_i     (rx_data),
      .word_o     (len_word),
      .word_nxt_o (len_nxt)
   );

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case leaves a value unassigned and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      len_clr   = 1'b0;
      len_shift = 1'b0;

      // Moore outputs decoded from the current state only.
      rx_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
      busy     = rx_ready;
      done     = (state_q == ST_DONE);
      err      = (state_q == ST_ERR);
      cpu_hold = (state_q != ST_DONE);

      accept = rx_valid && rx_ready;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LEN;
               cnt_d   = '0;
               acc_d   = '0;
               len_clr = 1'b1;
            end
         end

         ST_LEN: begin
            if (accept) begin
               len_shift = 1'b1;
               if (cnt_q == LAST_LEN_BYTE) begin
                  cnt_d   = '0;
                  state_d = len_ok(len_nxt, MAX_LEN) ? ST_DATA : ST_ERR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_DATA: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               wr_data_d = rx_data;
               acc_d     = acc_q + rx_data;
               cnt_d     = cnt_q + 1'b1;
               // len_word >= 4 here, so the subtraction cannot wrap.
               if (cnt_q == len_word - 1'b1) begin
                  state_d = ST_CSUM;
               end
            end
         end

         ST_CSUM: begin
            if (accept) begin
               state_d = (rx_data == acc_q) ? ST_DONE : ST_ERR;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader (IMEM_SIZE = 1024).
// Inputs change 1 ns after the rising edge; outputs and IMEM writes are
// sampled away from the rising edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_hold;

   int errors = 0;
   int checks = 0;

   // Captured IMEM writes and the write sequence expected for the current step.
   logic [31:0] log_addr [$];
   logic [7:0]  log_data [$];
   logic [7:0]  exp_q    [$];

   // Reference program: bytes sum to 0xF7 modulo 256.
   logic [7:0] prog [8] = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};

   imem_loader #(.IMEM_SIZE(1024)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .cpu_hold (cpu_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer one byte after 'idle' empty cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int idle);
      int n;
      rx_valid = 1'b0;
      repeat (idle) tick();
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (rx_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] len, input int max_idle);
      for (int i = 0; i < 4; i++) begin
         send_byte(len[8*i +: 8], $urandom_range(0, max_idle));
      end
   endtask

   // Sends exp_q as payload (after its length) followed by the checksum.
   task automatic send_load(input logic [7:0] csum, input int max_idle);
      send_len(32'(exp_q.size()), max_idle);
      for (int i = 0; i < exp_q.size(); i++) begin
         send_byte(exp_q[i], $urandom_range(0, max_idle));
      end
      send_byte(csum, $urandom_range(0, max_idle));
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_count"}, 32'(log_addr.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
         check({tag, "_addr"}, log_addr[i], 32'(i));
         check({tag, "_data"}, {24'd0, log_data[i]}, {24'd0, exp_q[i]});
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic load_prog();
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(prog[i]);
   endtask

   task automatic check_status(input string tag, input logic b, input logic d,
                               input logic e, input logic h, input logic r);
      check({tag, "_busy"},     {31'd0, busy},     {31'd0, b});
      check({tag, "_done"},     {31'd0, done},     {31'd0, d});
      check({tag, "_err"},      {31'd0, err},      {31'd0, e});
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
      check({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, r});
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      // ---- reset values ----
      repeat (3) tick();
      check_status("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("reset_wr_en",   {31'd0, wr_en}, 32'd0);
      check("reset_wr_addr", wr_addr,        32'd0);
      check("reset_wr_data", {24'd0, wr_data}, 32'd0);
      rst_n = 1'b1;
      tick();
      check_status("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // ---- good load ----
      load_prog();
      clear_log();
      pulse_start();
      check_status("len_state", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      send_load(8'hF7, 0);
      check_status("good", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("good");

      // ---- bad checksum ----
      clear_log();
      pulse_start();
      check_status("restart", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      send_load(8'h51, 0);
      check_status("badcsum", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_writes("badcsum");

      // ---- oversize length 0x402 ----
      clear_log();
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      check_status("len3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      send_byte(8'h00, 0);
      check_status("len402", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2) tick();
      check("len402_writes", 32'(log_addr.size()), 32'd0);

      // ---- length not a word multiple ----
      clear_log();
      pulse_start();
      send_len(32'd6, 0);
      check_status("len6", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // ---- zero length ----
      pulse_start();
      send_len(32'd0, 0);
      check_status("len0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2) tick();
      check("badlen_writes", 32'(log_addr.size()), 32'd0);

      // ---- smallest legal load: 4 bytes, sum 0x0A ----
      exp_q.delete();
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      clear_log();
      pulse_start();
      send_load(8'h0A, 0);
      check_status("len4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("len4");

      // ---- random stalls between bytes ----
      load_prog();
      clear_log();
      pulse_start();
      send_load(8'hF7, 5);
      check_status("stall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("stall");

      // ---- reset in the middle of the payload ----
      clear_log();
      pulse_start();
      send_len(32'd8, 0);
      for (int i = 0; i < 3; i++) send_byte(prog[i], 0);
      rst_n = 1'b0;
      #1;
      check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("midrst_wr_en",   {31'd0, wr_en}, 32'd0);
      check("midrst_wr_addr", wr_addr,        32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      clear_log();
      rx_valid = 1'b1;
      for (int i = 3; i < 8; i++) begin
         rx_data = prog[i];
         tick();
      end
      rx_valid = 1'b0;
      repeat (2) tick();
      check("midrst_writes", 32'(log_addr.size()), 32'd0);
      check_status("midrst_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // ---- start in DATA ignored, start in DONE reloads ----
      load_prog();
      clear_log();
      pulse_start();
      send_len(32'd8, 0);
      send_byte(prog[0], 0);
      send_byte(prog[1], 0);
      pulse_start();
      check_status("start_in_data", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 2; i < 8; i++) send_byte(prog[i], 0);
      send_byte(8'hF7, 0);
      check_status("ignored_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("ignored_start");

      exp_q.delete();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      clear_log();
      pulse_start();
      check_status("reload", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      send_load(8'hAA, 0);
      check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_writes("reload");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
